// File: rtl/data_memory_responder.sv
// data_memory_responder: off-chip data-memory model answering the data-cache
// refill / write-back path over a req/ack handshake. One line-sized read or
// write per transaction, completed after LATENCY wait cycles with a one-cycle
// ack pulse.
//
// Ports:
//   clk_i    - clock, rising edge
//   rst_i    - asynchronous active-low reset
//   req_i    - request valid, held by the initiator until ack_o
//   write_i  - 1 = write line, 0 = read line
//   addr_i   - byte address (line index taken from the bits above the offset)
//   wdata_i  - write line data
//   ack_o    - one-cycle completion pulse
//   rdata_o  - read data (write data on writes), held until the next completion
//   busy_o   - transaction in flight
//   err_o    - sticky protocol error (only with DMEM_RESP_CHECK_EN defined)
//
// Build option: define DMEM_RESP_CHECK_EN to compile the request-stability
// checker; otherwise err_o is tied low.
module data_memory_responder #(
  parameter int unsigned DATA_W  = 256,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 10
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              write_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic              ack_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o,
  output logic              err_o
);

  localparam int unsigned OFF_W = $clog2(DATA_W / 8);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic               wr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [IDX_W-1:0]   idx_c;
  logic               start_c;
  logic               access_c;
  logic               unused_addr;

  // Offset and upper address bits are dropped, so addresses wrap modulo DEPTH.
  assign idx_c       = addr_i[OFF_W +: IDX_W];
  assign unused_addr = ^addr_i;
  assign start_c     = (state_q == ST_IDLE) && req_i;
  assign access_c    = (state_q == ST_WAIT) && (cnt_q == '0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_i) state_d = ST_WAIT;
      ST_WAIT: if (cnt_q == '0) state_d = ST_ACK;
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State, latched request, wait counter and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      ack_o   <= 1'b0;
      busy_o  <= 1'b0;
      rdata_o <= '0;
    end else begin
      state_q <= state_d;
      ack_o   <= (state_d == ST_ACK);
      busy_o  <= (state_d != ST_IDLE);
      if (start_c) begin
        wr_q    <= write_i;
        idx_q   <= idx_c;
        wdata_q <= wdata_i;
        cnt_q   <= CNT_W'(LATENCY - 1);
      end else if ((state_q == ST_WAIT) && (cnt_q != '0)) begin
        cnt_q <= cnt_q - CNT_W'(1);
      end
      if (access_c) begin
        rdata_o <= wr_q ? wdata_q : mem[idx_q];
      end
    end
  end

  // Line array; never reset. A reset during WAIT forces IDLE, so a pending
  // write cannot reach this port.
  always_ff @(posedge clk_i) begin
    if (access_c && wr_q) begin
      mem[idx_q] <= wdata_q;
    end
  end

`ifdef DMEM_RESP_CHECK_EN
  logic [ADDR_W-1:0] addr_q;

  // Full request address kept only for the stability check
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      addr_q <= '0;
    end else if (start_c) begin
      addr_q <= addr_i;
    end
  end

  // Sticky flag: request dropped or changed while the transaction waits
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      err_o <= 1'b0;
    end else if ((state_q == ST_WAIT) &&
                 (!req_i || (addr_i != addr_q) || (write_i != wr_q) ||
                  (wdata_i != wdata_q))) begin
      err_o <= 1'b1;
    end
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_data_memory_responder.sv
module tb_data_memory_responder;

  localparam int unsigned DW    = 256;
  localparam int unsigned AW    = 32;
  localparam int unsigned DEP   = 512;
  localparam int          LAT   = 10;
  localparam int unsigned OFF_W = 5;
  localparam int unsigned IDX_W = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req = 1'b0;
  logic          wr = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          err;

  data_memory_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_i(rst_n), .req_i(req), .write_i(wr), .addr_i(addr),
    .wdata_i(wdata), .ack_o(ack), .rdata_o(rdata), .busy_o(busy), .err_o(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

`ifdef DMEM_RESP_CHECK_EN
  localparam bit CHECK_ON = 1'b1;
`else
  localparam bit CHECK_ON = 1'b0;
`endif

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a transaction accepted at edge s is performed at edge
  // s+LAT, acks during the cycle after that edge, and the next request can be
  // accepted from edge s+LAT+2 onward.
  logic [DW-1:0] m_mem [DEP];
  bit            m_val [DEP];
  int            s = -1000;
  logic          l_w;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_data;
  logic [DW-1:0] e_rd = '0;
  bit            e_known = 1'b1;
  bit            e_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    int n;
    int li;
    if (!rst_n) begin
      s = -1000; e_rd = '0; e_known = 1'b1; e_err = 1'b0;
    end else begin
      n = cyc + 1;
      if (n == s + LAT) begin
        li = int'(l_addr[OFF_W +: IDX_W]);
        if (l_w) begin
          m_mem[li] = l_data; m_val[li] = 1'b1; e_rd = l_data; e_known = 1'b1;
        end else begin
          e_rd = m_mem[li]; e_known = m_val[li];
        end
      end
      if (CHECK_ON && n > s && n <= s + LAT &&
          (!req || addr != l_addr || wr != l_w || wdata != l_data))
        e_err = 1'b1;
      if (n >= s + LAT + 2 && req) begin
        s = n; l_w = wr; l_addr = addr; l_data = wdata;
      end
    end
  end

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", DW'(ack), DW'(cyc == s + LAT));
      chk("busy", DW'(busy), DW'(cyc >= s && cyc <= s + LAT));
      chk("err", DW'(err), DW'(e_err));
      if (e_known) chk("rdata", rdata, e_rd);
    end
  end

  // Drives one transaction starting just after a rising edge; returns the
  // ack delay in edges from the edge before the request, and the ack cycle.
  task automatic txn(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit keep, output int lat, output int ack_at,
                     output logic [DW-1:0] rd);
    int  t0;
    bit  seen;
    t0 = cyc; seen = 1'b0; lat = -1; ack_at = -1; rd = '0;
    req = 1'b1; wr = w; addr = a; wdata = d;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        seen = 1'b1; ack_at = cyc; lat = cyc - t0; rd = rdata;
      end
    end
    if (!seen) chk("ack_timeout", DW'(0), DW'(1));
    @(posedge clk); #1;
    if (!keep) begin
      req = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #3;
    rst_n = 1'b0; req = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  function automatic logic [DW-1:0] rnd_line();
    logic [DW-1:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  initial begin
    int            lat;
    int            a1;
    int            a2;
    logic [DW-1:0] rd;
    logic [DW-1:0] a5;
    logic [AW-1:0] ra;
    bit            k;
    int            ok;

    for (int i = 0; i < 32; i++) a5[i*8 +: 8] = 8'hA5;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    chk_en = 1'b1;
    chk("reset_ack", DW'(ack), DW'(0));
    chk("reset_busy", DW'(busy), DW'(0));
    chk("reset_rdata", rdata, DW'(0));
    @(posedge clk); #1;

    // Write then read a line; ack lands LAT+1 edges after the request edge
    txn(1'b1, 32'h40, a5, 1'b0, lat, a1, rd);
    chk("wr_latency", DW'(lat), DW'(11));
    txn(1'b0, 32'h40, rnd_line(), 1'b0, lat, a1, rd);
    chk("rd_latency", DW'(lat), DW'(11));
    chk("rd_a5", rd, a5);

    // Address wrap modulo DEPTH lines and ignored offset bits
    txn(1'b1, 32'h4000, DW'(16'h1234), 1'b0, lat, a1, rd);
    txn(1'b0, 32'h0000, '0, 1'b0, lat, a1, rd);
    chk("wrap_0000", rd, DW'(16'h1234));
    txn(1'b0, 32'h401F, '0, 1'b0, lat, a1, rd);
    chk("wrap_401f", rd, DW'(16'h1234));

    // Back-to-back reads with req held high
    txn(1'b0, 32'h40, '0, 1'b1, lat, a1, rd);
    txn(1'b0, 32'h0, '0, 1'b0, lat, a2, rd);
    chk("b2b_spacing", DW'(a2 - a1), DW'(12));

    // Reset mid-WAIT aborts a pending write
    txn(1'b1, 32'h80, DW'(8'h11), 1'b0, lat, a1, rd);
    req = 1'b1; wr = 1'b1; addr = 32'h80; wdata = DW'(8'hFF);
    @(posedge clk);
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0; req = 1'b0;
    #1;
    chk("abort_ack", DW'(ack), DW'(0));
    chk("abort_busy", DW'(busy), DW'(0));
    chk("abort_rdata", rdata, DW'(0));
    chk("abort_err", DW'(err), DW'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    txn(1'b0, 32'h80, '0, 1'b0, lat, a1, rd);
    chk("abort_no_commit", rd, DW'(8'h11));

    // Request withdrawn during WAIT
    req = 1'b1; wr = 1'b0; addr = 32'h100; wdata = '0;
    a1 = cyc;
    repeat (3) @(posedge clk);
    #1 req = 1'b0;
    ok = 0;
    for (int i = 0; i < 100 && ok == 0; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ok = cyc - a1;
    end
    chk("withdraw_ack_latency", DW'(ok), DW'(11));
    chk("withdraw_err", DW'(err), DW'(CHECK_ON));
    repeat (3) @(posedge clk);
    #1 chk("withdraw_err_sticky", DW'(err), DW'(CHECK_ON));
    pulse_reset();
    chk("err_cleared", DW'(err), DW'(0));

    // Randomized traffic over a handful of lines with random aliasing bits
    for (int i = 0; i < 60; i++) begin
      ra = $urandom();
      ra[OFF_W +: IDX_W] = IDX_W'(($urandom_range(0, 7) * 61) % DEP);
      k = (i != 59) && ($urandom_range(0, 2) == 0);
      txn(1'(($urandom_range(0, 1))), ra, rnd_line(), k, lat, a1, rd);
      chk("rand_latency", DW'(lat), DW'(LAT + 1));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
